// File: rtl/oled_cap_pkg.sv
// Shared definitions for the OLED SPI capture block: SSD1306 opcodes,
// addressing-mode and parser-state types, and the skip-one opcode test.
package oled_cap_pkg;

   localparam logic [7:0] OP_ADDR_MODE = 8'h20;
   localparam logic [7:0] OP_COL_ADDR  = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
   localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISP_ON   = 8'hAF;
   localparam logic [7:0] OP_PAGE_BASE = 8'hB0;
   localparam logic [7:0] OP_REMAP_OFF = 8'hA0;
   localparam logic [7:0] OP_REMAP_ON  = 8'hA1;

   typedef enum logic {
      MODE_HORIZ,
      MODE_PAGE
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      ARG1,
      ARG2,
      SKIP1
   } parse_state_e;

   // Opcodes that carry one argument byte the capture model does not use.
   function automatic logic is_skip1(input logic [7:0] op);
      case (op)
         8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: is_skip1 = 1'b1;
         default:                                                  is_skip1 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/oled_spi_rx_shift.sv
// SPI receive front end: synchronizes CS/SCLK/SDIN/DC into the CLK domain,
// detects SCLK rising edges while selected and assembles MSB-first bytes.
// Handshake: valid_o is a single-cycle strobe with no back-pressure; byte_o
// and dc_o hold the most recent byte until the next strobe.
module oled_spi_rx_shift #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_i,
   input  logic       sclk_i,
   input  logic       sdin_i,
   input  logic       dc_i,
   output logic [7:0] byte_o,
   output logic       dc_o,
   output logic       valid_o
);

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdin_sync_q, dc_sync_q;
   logic       cs_s, sclk_s, sdin_s, dc_s;
   logic       sclk_prev_q, cs_prev_q;
   logic       sclk_edge;
   logic [6:0] shreg_q, shreg_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] byte_q, byte_d;
   logic       dc_q, dc_d;
   logic       valid_q, valid_d;

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign sdin_s = sdin_sync_q[SYNC_STAGES-1];
   assign dc_s   = dc_sync_q[SYNC_STAGES-1];

   // A rising edge still counts when CS deasserts in the same cycle, so a
   // byte whose last edge coincides with CS release still completes.
   assign sclk_edge = sclk_s & ~sclk_prev_q & (~cs_s | ~cs_prev_q);

   // Synchronizer chains plus one-cycle history of synced CS and SCLK.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '1;
         sdin_sync_q <= '0;
         dc_sync_q   <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin_i};
         dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   // Shift/count logic: the 8th edge latches the byte and DC; CS high drops any partial byte.
   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      byte_d   = byte_q;
      dc_d     = dc_q;
      valid_d  = 1'b0;
      if (sclk_edge) begin
         shreg_d = {shreg_q[5:0], sdin_s};
         if (bitcnt_q == 3'd7) begin
            byte_d   = {shreg_q, sdin_s};
            dc_d     = dc_s;
            valid_d  = 1'b1;
            bitcnt_d = 3'd0;
         end else begin
            bitcnt_d = bitcnt_q + 3'd1;
         end
      end
      if (cs_s) begin
         bitcnt_d = 3'd0;
      end
   end

   // Byte assembly state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
         byte_q   <= '0;
         dc_q     <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         byte_q   <= byte_d;
         dc_q     <= dc_d;
         valid_q  <= valid_d;
      end
   end

   assign byte_o  = byte_q;
   assign dc_o    = dc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/oled_spi_capture.sv
// Display-side model of the OLED SPI link: decodes the SSD1306 command
// subset and stores data bytes into a PAGES x COLS framebuffer with a
// synchronous read-first read port. Optional column remap (0xA0/0xA1) is
// built when OLED_CAP_SEGREMAP_EN is defined.
module oled_spi_capture
   import oled_cap_pkg::*;
#(
   parameter int COLS        = 128,
   parameter int PAGES       = 4,
   parameter int SYNC_STAGES = 2,
   localparam int AW = $clog2(PAGES * COLS),
   localparam int CW = $clog2(COLS),
   localparam int PW = $clog2(PAGES)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CS,
   input  logic          SCLK,
   input  logic          SDIN,
   input  logic          DC,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          byte_valid,
   output logic [7:0]    byte_data,
   output logic          byte_is_data,
   output logic          disp_on,
   output logic          frame_done,
   output logic [1:0]    dbg_state_o
);

   logic [7:0] rx_byte;
   logic       rx_dc, rx_valid;

   oled_spi_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk_i   (CLK),
      .rst_i   (RST),
      .cs_i    (CS),
      .sclk_i  (SCLK),
      .sdin_i  (SDIN),
      .dc_i    (DC),
      .byte_o  (rx_byte),
      .dc_o    (rx_dc),
      .valid_o (rx_valid)
   );

   parse_state_e  state_q, state_d;
   mode_e         mode_q, mode_d;
   logic [7:0]    opc_q, opc_d;
   logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
   logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
   logic          disp_on_q, disp_on_d;
   logic          frame_done_q, frame_done_d;
   logic          remap_q, remap_d;
   logic          fb_we;
   logic [CW-1:0] col_eff;
   logic [AW-1:0] wr_addr;
   logic [7:0]    rd_data_q;
   logic [7:0]    fb_q [PAGES*COLS];

`ifdef OLED_CAP_SEGREMAP_EN
   // Segment remap flag, only present when the remap option is built.
   always_ff @(posedge CLK) begin
      if (RST) remap_q <= 1'b0;
      else     remap_q <= remap_d;
   end
`else
   assign remap_q = 1'b0;
`endif

   // Remap mirrors the column (COLS-1-col) on writes only.
   assign col_eff = remap_q ? ~col_q : col_q;
   assign wr_addr = {page_q, col_eff};

   // Parser next-state, address counters and data-write decode.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      opc_d        = opc_q;
      col_d        = col_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      page_d       = page_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      disp_on_d    = disp_on_q;
      frame_done_d = 1'b0;
      remap_d      = remap_q;
      fb_we        = 1'b0;
      if (rx_valid) begin
         if (rx_dc) begin
            // Data aborts any pending argument and is written at the current address.
            state_d = IDLE;
            fb_we   = 1'b1;
            if (mode_q == MODE_HORIZ && col_q == col_end_q) begin
               col_d = col_start_q;
               if (page_q == page_end_q) begin
                  page_d       = page_start_q;
                  frame_done_d = 1'b1;
               end else begin
                  page_d = page_q + PW'(1);
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (rx_byte == OP_COL_ADDR || rx_byte == OP_PAGE_ADDR || rx_byte == OP_ADDR_MODE) begin
                     opc_d   = rx_byte;
                     state_d = ARG1;
                  end else if (is_skip1(rx_byte)) begin
                     state_d = SKIP1;
                  end else if (rx_byte[7:3] == OP_PAGE_BASE[7:3]) begin
                     if (mode_q == MODE_PAGE) page_d = rx_byte[PW-1:0];
                  end else if (rx_byte[7:4] == 4'h0) begin
                     col_d = (col_q & ~CW'(8'h0F)) | CW'(rx_byte[3:0]);
                  end else if (rx_byte[7:4] == 4'h1) begin
                     col_d = (col_q & ~CW'(8'h70)) | CW'({1'b0, rx_byte[2:0], 4'h0});
                  end else if (rx_byte == OP_DISP_ON) begin
                     disp_on_d = 1'b1;
                  end else if (rx_byte == OP_DISP_OFF) begin
                     disp_on_d = 1'b0;
`ifdef OLED_CAP_SEGREMAP_EN
                  end else if (rx_byte == OP_REMAP_ON) begin
                     remap_d = 1'b1;
                  end else if (rx_byte == OP_REMAP_OFF) begin
                     remap_d = 1'b0;
`endif
                  end
               end
               ARG1: begin
                  state_d = IDLE;
                  if (opc_q == OP_COL_ADDR) begin
                     col_start_d = rx_byte[CW-1:0];
                     state_d     = ARG2;
                  end else if (opc_q == OP_PAGE_ADDR) begin
                     page_start_d = rx_byte[PW-1:0];
                     state_d      = ARG2;
                  end else begin
                     mode_d = (rx_byte[1:0] == 2'd0) ? MODE_HORIZ : MODE_PAGE;
                  end
               end
               ARG2: begin
                  state_d = IDLE;
                  if (opc_q == OP_COL_ADDR) begin
                     col_end_d = rx_byte[CW-1:0];
                     col_d     = col_start_q;
                  end else begin
                     page_end_d = rx_byte[PW-1:0];
                     page_d     = page_start_q;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Parser and address-counter registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         mode_q       <= MODE_PAGE;
         opc_q        <= '0;
         col_q        <= '0;
         col_start_q  <= '0;
         col_end_q    <= CW'(COLS - 1);
         page_q       <= '0;
         page_start_q <= '0;
         page_end_q   <= PW'(PAGES - 1);
         disp_on_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         opc_q        <= opc_d;
         col_q        <= col_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         page_q       <= page_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
         disp_on_q    <= disp_on_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Framebuffer write port; contents survive reset.
   always_ff @(posedge CLK) begin
      if (fb_we) fb_q[wr_addr] <= rx_byte;
   end

   // Registered read port; a same-cycle write to the address returns old data.
   always_ff @(posedge CLK) begin
      if (RST) rd_data_q <= '0;
      else     rd_data_q <= fb_q[rd_addr];
   end

   assign rd_data      = rd_data_q;
   assign byte_valid   = rx_valid;
   assign byte_data    = rx_byte;
   assign byte_is_data = rx_dc;
   assign disp_on      = disp_on_q;
   assign frame_done   = frame_done_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_oled_spi_capture.sv
// Bench for oled_spi_capture: drives SPI bytes, keeps a byte-level model of
// the display addressing and framebuffer, and compares DUT outputs to it.
module tb_oled_spi_capture;

  localparam int COLS  = 128;
  localparam int PAGES = 4;
  localparam int NFB   = COLS * PAGES;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs, sclk, sdin, dc;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       disp_on;
  logic       frame_done;
  logic [1:0] dbg_state;

  oled_spi_capture #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(2)) dut (
    .CLK          (clk),
    .RST          (rst),
    .CS           (cs),
    .SCLK         (sclk),
    .SDIN         (sdin),
    .DC           (dc),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .disp_on      (disp_on),
    .frame_done   (frame_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int bv_count = 0;
  int dv_count = 0;
  int fd_count = 0;
  int fd_at    = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- model ----------------
  logic [8:0] exp_q[$];
  logic [7:0] m_fb [NFB];
  bit         m_fbv[NFB];
  int m_col = 0, m_page = 0, m_cs = 0, m_ce = COLS - 1, m_ps = 0, m_pe = PAGES - 1;
  bit m_horiz = 0;
  bit m_disp = 0;
  int m_pend = 0;  // 0 none, 1 col start, 2 col end, 3 page start, 4 page end, 5 mode, 6 ignored arg
  int m_frames = 0;

  function automatic void model_byte(input bit is_dat, input logic [7:0] b);
    int a;
    int v;
    v = int'(b);
    if (is_dat) begin
      m_pend = 0;
      a = m_page * COLS + m_col;
      m_fb[a]  = b;
      m_fbv[a] = 1'b1;
      if (m_horiz && m_col == m_ce) begin
        m_col = m_cs;
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_frames++;
        end else begin
          m_page = (m_page + 1) % PAGES;
        end
      end else begin
        m_col = (m_col + 1) % COLS;
      end
    end else if (m_pend == 1) begin m_cs = v % COLS; m_pend = 2;
    end else if (m_pend == 2) begin m_ce = v % COLS; m_col = m_cs; m_pend = 0;
    end else if (m_pend == 3) begin m_ps = v % PAGES; m_pend = 4;
    end else if (m_pend == 4) begin m_pe = v % PAGES; m_page = m_ps; m_pend = 0;
    end else if (m_pend == 5) begin m_horiz = ((v % 4) == 0); m_pend = 0;
    end else if (m_pend == 6) begin m_pend = 0;
    end else begin
      if (v == 'h21) m_pend = 1;
      else if (v == 'h22) m_pend = 3;
      else if (v == 'h20) m_pend = 5;
      else if (v == 'h81 || v == 'h8D || v == 'hA8 || v == 'hD3 || v == 'hD5 ||
               v == 'hD9 || v == 'hDA || v == 'hDB) m_pend = 6;
      else if (v >= 'hB0 && v <= 'hB7) begin
        if (!m_horiz) m_page = (v - 'hB0) % PAGES;
      end
      else if (v < 'h10) m_col = (m_col / 16) * 16 + v;
      else if (v < 'h20) m_col = (m_col % 16) + (v % 8) * 16;
      else if (v == 'hAF) m_disp = 1;
      else if (v == 'hAE) m_disp = 0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input bit is_dat, input logic [7:0] b, input int nbits);
    cs = 1'b0;
    wait_clk(3);
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk = 1'b0;
      sdin = b[i];
      dc   = is_dat;
      wait_clk(3);
      sclk = 1'b1;
      wait_clk(3);
    end
    cs = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_byte(input bit is_dat, input logic [7:0] b);
    exp_q.push_back({is_dat, b});
    model_byte(is_dat, b);
    spi_bits(is_dat, b, 8);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    spi_bits(1'b0, b, nbits);
  endtask

  task automatic settle();
    wait_clk(8);
  endtask

  task automatic check_fb(input int a, input logic [7:0] exp, input string name);
    rd_addr = 9'(a);
    wait_clk(1);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic sweep_fb(input string name);
    for (int a = 0; a < NFB; a++) begin
      if (m_fbv[a]) check_fb(a, m_fb[a], name);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        bv_count++;
        if (byte_is_data) dv_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte_valid", 32'(byte_valid), 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("byte_data", 32'(byte_data), 32'(e[7:0]));
          chk("byte_is_data", 32'(byte_is_data), 32'(e[8]));
        end
      end
      if (frame_done) begin
        fd_count++;
        fd_at = dv_count;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_dv, fd0, bv0;
    rst = 1'b1; cs = 1'b1; sclk = 1'b1; sdin = 1'b0; dc = 1'b0; rd_addr = '0;
    for (int a = 0; a < NFB; a++) m_fbv[a] = 1'b0;
    wait_clk(4);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_byte_is_data", 32'(byte_is_data), 32'd0);
    chk("rst_disp_on", 32'(disp_on), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    wait_clk(2);

    // Display on, horizontal mode
    send_byte(1'b0, 8'hAF);
    send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h00);
    settle();
    chk("disp_on_after_AF", 32'(disp_on), 32'd1);
    chk("disp_on_model", 32'(disp_on), 32'(m_disp));
    chk("cmd_pulse_count", 32'(bv_count), 32'd3);

    // Full horizontal frame
    base_dv = dv_count;
    for (int i = 0; i < NFB; i++) send_byte(1'b1, 8'(i));
    settle();
    chk("frame_done_count", 32'(fd_count), 32'd1);
    chk("frame_done_model", 32'(fd_count), 32'(m_frames));
    chk("frame_done_on_byte", 32'(fd_at - base_dv), 32'd512);
    sweep_fb("fb_full_frame");
    check_fb(300, 8'd44, "fb_300_literal");
    send_byte(1'b1, 8'hE1);
    settle();
    check_fb(0, 8'hE1, "wrap_to_col0_page0");

    // Page mode addressing
    send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'hB2);
    send_byte(1'b0, 8'h05);
    send_byte(1'b0, 8'h11);
    send_byte(1'b1, 8'hAA);
    send_byte(1'b1, 8'h55);
    send_byte(1'b0, 8'h0F);
    send_byte(1'b0, 8'h17);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    settle();
    check_fb(2*128+21, 8'hAA, "page_mode_col21");
    check_fb(2*128+22, 8'h55, "page_mode_col22");
    check_fb(2*128+127, 8'h12, "page_mode_col127");
    check_fb(2*128+0, 8'h34, "page_mode_col_wrap");

    // Column/page window in horizontal mode
    fd0 = fd_count;
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h10); send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(1'b1, 8'(8'hC0 + i));
    settle();
    chk("win_no_frame_early", 32'(fd_count - fd0), 32'd0);
    send_byte(1'b1, 8'hC3);
    settle();
    chk("win_frame_after_4th", 32'(fd_count - fd0), 32'd1);
    send_byte(1'b1, 8'hC4);
    settle();
    check_fb(144, 8'hC4, "win_144");
    check_fb(145, 8'hC1, "win_145");
    check_fb(272, 8'hC2, "win_272");
    check_fb(273, 8'hC3, "win_273");

    // Partial byte discarded by CS
    bv0 = bv_count;
    send_partial(8'hFF, 5);
    send_byte(1'b0, 8'h3C);
    settle();
    chk("partial_pulse_count", 32'(bv_count - bv0), 32'd1);
    chk("partial_byte_data", 32'(byte_data), 32'h3C);

    // Data byte aborts an argument sequence
    send_byte(1'b0, 8'h21);
    settle();
    chk("arg1_pending", 32'(dbg_state == 2'd0), 32'd0);
    send_byte(1'b1, 8'h77);
    settle();
    chk("abort_idle", 32'(dbg_state), 32'd0);
    send_byte(1'b1, 8'h88);
    settle();
    check_fb(145, 8'h77, "abort_data_written");
    check_fb(272, 8'h88, "col_start_kept");

    sweep_fb("fb_final");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
